// File: rtl/inv_check_seq.sv
// rtl/inv_check_seq.sv - exhaustive invariant sweep against an external Skolem witness block
module inv_check_seq #(
    parameter int SK_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] sk_in,
    input  logic [3:0] sk_x,
    output logic       busy,
    output logic       done,
    output logic [8:0] pass_cnt,
    output logic [8:0] fail_cnt,
    output logic [8:0] skip_cnt,
    output logic       ff_valid,
    output logic [7:0] ff_vec,
    output logic [3:0] ff_x
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [7:0] r_vec;
    logic [1:0] r_wait;
    logic       r_busy;
    logic       r_done;
    logic [8:0] r_pass;
    logic [8:0] r_fail;
    logic [8:0] r_skip;
    logic       r_ff_valid;
    logic [7:0] r_ff_vec;
    logic [3:0] r_ff_x;

    logic [3:0] w_s;
    logic [3:0] w_t;
    logic [3:0] w_shift;
    logic       w_ic;
    logic       w_sat;

    // Invariant terms: s is the low nibble, t the high nibble of the current vector.
    // An arithmetic shift of a 4-bit value by 3 or more already yields all sign bits.
    assign w_s     = r_vec[3:0];
    assign w_t     = r_vec[7:4];
    assign w_shift = 4'($signed(w_s) >>> sk_x);
    assign w_ic    = w_s[3] | (w_s >= w_t);
    assign w_sat   = (w_shift >= w_t);

    assign sk_in    = r_vec;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass_cnt = r_pass;
    assign fail_cnt = r_fail;
    assign skip_cnt = r_skip;
    assign ff_valid = r_ff_valid;
    assign ff_vec   = r_ff_vec;
    assign ff_x     = r_ff_x;

    // Sweep sequencer; abort wins over start and over the CHECK update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= 8'h00;
            r_wait     <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 9'd0;
            r_fail     <= 9'd0;
            r_skip     <= 9'd0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= 8'h00;
            r_ff_x     <= 4'h0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_APPLY;
                        r_vec      <= 8'h00;
                        r_busy     <= 1'b1;
                        r_pass     <= 9'd0;
                        r_fail     <= 9'd0;
                        r_skip     <= 9'd0;
                        r_ff_valid <= 1'b0;
                        r_ff_vec   <= 8'h00;
                        r_ff_x     <= 4'h0;
                    end
                end
                S_APPLY: begin
                    if (SK_LAT == 0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_WAIT;
                        r_wait  <= 2'(SK_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                S_CHECK: begin
                    if (!w_ic) begin
                        r_skip <= r_skip + 9'd1;
                    end else if (w_sat) begin
                        r_pass <= r_pass + 9'd1;
                    end else begin
                        r_fail <= r_fail + 9'd1;
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_vec   <= r_vec;
                            r_ff_x     <= sk_x;
                        end
                    end
                    if (r_vec == 8'hFF) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_vec   <= r_vec + 8'd1;
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_check_seq.sv
// tb/tb_inv_check_seq.sv - scoreboard bench for inv_check_seq
module tb_inv_check_seq;

    typedef struct {
        int done;
        int pass;
        int fail;
        int skip;
        int ffv;
        int ffvec;
        int ffx;
        int cyc;
        int skin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       start3 = 1'b0, abort3 = 1'b0;
    logic       mode_const = 1'b0;
    logic [7:0] sk_in0, sk_in3;
    logic [3:0] sk_x0, sk_x3;
    logic       busy0, done0, busy3, done3;
    logic [8:0] pass0, fail0, skip0, pass3, fail3, skip3;
    logic       ffv0, ffv3;
    logic [7:0] ffvec0, ffvec3;
    logic [3:0] ffx0, ffx3;
    logic [3:0] d1, d2, d3;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q0[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    inv_check_seq #(.SK_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .sk_in(sk_in0), .sk_x(sk_x0), .busy(busy0), .done(done0),
        .pass_cnt(pass0), .fail_cnt(fail0), .skip_cnt(skip0),
        .ff_valid(ffv0), .ff_vec(ffvec0), .ff_x(ffx0)
    );

    inv_check_seq #(.SK_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .sk_in(sk_in3), .sk_x(sk_x3), .busy(busy3), .done(done3),
        .pass_cnt(pass3), .fail_cnt(fail3), .skip_cnt(skip3),
        .ff_valid(ffv3), .ff_vec(ffvec3), .ff_x(ffx3)
    );

    // Ideal witness: no shift if s>=t already holds, else shift 3 to replicate the sign bit.
    function automatic logic [3:0] ideal_x(input logic [7:0] v);
        return (v[3:0] >= v[7:4]) ? 4'd0 : 4'd3;
    endfunction

    assign sk_x0 = mode_const ? 4'd0 : ideal_x(sk_in0);

    always @(posedge clk) begin
        d1 <= ideal_x(sk_in3);
        d2 <= d1;
        d3 <= d2;
    end
    assign sk_x3 = d3;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare(input string tag, input exp_t e, input int dn, input int p,
                           input int f, input int s, input int fv, input int fvec,
                           input int fx, input int cyc, input int skin);
        chk({tag, "_done"}, dn, e.done);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_fail"}, f, e.fail);
        chk({tag, "_skip"}, s, e.skip);
        chk({tag, "_ff_valid"}, fv, e.ffv);
        chk({tag, "_ff_vec"}, fvec, e.ffvec);
        chk({tag, "_ff_x"}, fx, e.ffx);
        if (e.cyc >= 0) chk({tag, "_cycles"}, cyc, e.cyc);
        if (e.skin >= 0) chk({tag, "_sk_in"}, skin, e.skin);
    endtask

    // Monitor for the SK_LAT=0 instance: an end of busy is a response.
    initial begin
        int   cyc;
        logic prev;
        exp_t e;
        cyc = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!prev && busy0) cyc = 0;
            else if (prev) cyc++;
            if (prev && !busy0) begin
                if (q0.size() == 0) begin
                    chk("sb0_unexpected_end", 1, 0);
                end else begin
                    e = q0.pop_front();
                    compare("d0", e, int'(done0), int'(pass0), int'(fail0), int'(skip0),
                            int'(ffv0), int'(ffvec0), int'(ffx0), cyc, int'(sk_in0));
                end
            end
            prev = busy0;
        end
    end

    // Monitor for the SK_LAT=3 instance.
    initial begin
        int   cyc;
        logic prev;
        exp_t e;
        cyc = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!prev && busy3) cyc = 0;
            else if (prev) cyc++;
            if (prev && !busy3) begin
                if (q3.size() == 0) begin
                    chk("sb3_unexpected_end", 1, 0);
                end else begin
                    e = q3.pop_front();
                    compare("d3", e, int'(done3), int'(pass3), int'(fail3), int'(skip3),
                            int'(ffv3), int'(ffvec3), int'(ffx3), cyc, int'(sk_in3));
                end
            end
            prev = busy3;
        end
    end

    task automatic wait_q0(input int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (q0.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_response_d0", ok, 1);
    endtask

    task automatic wait_q3(input int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (q3.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("wait_response_d3", ok, 1);
    endtask

    task automatic wait_vec0(input logic [7:0] v);
        int ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sk_in0 == v) begin
                ok = 1;
                break;
            end
        end
        chk("wait_vec_d0", ok, 1);
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    initial begin
        exp_t e_ideal, e_ideal3, e_abort, e_reset, e_const;
        int   saw;
        e_ideal  = '{done: 1, pass: 164, fail: 0,  skip: 92, ffv: 0, ffvec: 0,    ffx: 0, cyc: 512,  skin: 255};
        e_ideal3 = '{done: 1, pass: 164, fail: 0,  skip: 92, ffv: 0, ffvec: 0,    ffx: 0, cyc: 1280, skin: 255};
        e_abort  = '{done: 0, pass: 58,  fail: 0,  skip: 6,  ffv: 0, ffvec: 0,    ffx: 0, cyc: -1,   skin: -1};
        e_reset  = '{done: 0, pass: 0,   fail: 0,  skip: 0,  ffv: 0, ffvec: 0,    ffx: 0, cyc: -1,   skin: 0};
        e_const  = '{done: 1, pass: 136, fail: 28, skip: 92, ffv: 1, ffvec: 8'h98, ffx: 0, cyc: 512, skin: 255};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy0), 0);
        chk("reset_done", int'(done0), 0);
        chk("reset_sk_in", int'(sk_in0), 0);
        chk("reset_counts", int'(pass0) + int'(fail0) + int'(skip0), 0);
        chk("reset_ff_valid", int'(ffv0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain ideal sweeps on both latencies.
        q0.push_back(e_ideal);
        q3.push_back(e_ideal3);
        start0 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start3 = 1'b0;
        chk("busy_after_start", int'(busy0), 1);
        wait_q0(2000);
        repeat (5) @(posedge clk);
        #1;
        chk("held_pass_after_done", int'(pass0), 164);
        chk("done_one_cycle", int'(done0), 0);

        // Abort in CHECK of vector 0x40.
        q0.push_back(e_abort);
        pulse_start0();
        wait_vec0(8'h40);
        @(posedge clk);
        #1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        wait_q0(20);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) saw = 1;
        end
        chk("quiet_after_abort", saw, 0);
        chk("frozen_pass_after_abort", int'(pass0), 58);

        // Restart clears counters and sweeps from 0x00.
        q0.push_back(e_ideal);
        pulse_start0();
        chk("restart_vec0", int'(sk_in0), 0);
        wait_q0(2000);
        wait_q3(2000);

        // start mid-sweep is ignored; cycle count would expose a restart.
        q0.push_back(e_ideal);
        pulse_start0();
        wait_vec0(8'h80);
        pulse_start0();
        wait_q0(2000);

        // Reset mid-sweep forces reset values before any clock edge.
        q0.push_back(e_reset);
        pulse_start0();
        wait_vec0(8'h80);
        rst_n = 1'b0;
        wait_q0(10);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh sweep after reset with a constant zero witness.
        mode_const = 1'b1;
        q0.push_back(e_const);
        pulse_start0();
        wait_q0(2000);
        mode_const = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inv_check_seq.md
INV_CHECK_SEQ -- requirements
Module: inv_check_seq

Interface
REQ-001 SHALL have parameter SK_LAT, default 0, range 0..3: cycles the external Skolem block needs between sk_in change and valid sk_x.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  terminates a sweep in progress.
REQ-006 SHALL have port sk_in  output  8  vector to Skolem block: [3:0]=s, [7:4]=t.
REQ-007 SHALL have port sk_x  input  4  witness x returned by Skolem block.
REQ-008 SHALL have port busy  output  1  high from accepted start until done/abort.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port pass_cnt, fail_cnt, skip_cnt  output  9 each  result counters.
REQ-011 SHALL have port ff_valid  output  1, ff_vec  output  8, ff_x  output  4: first-failure capture.

Function
REQ-012 SHALL sweep vec 0x00..0xFF in increasing order; s=vec[3:0], t=vec[7:4]; sk_in=vec (registered).
REQ-013 SHALL use FSM IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | DONE) -> IDLE.
REQ-014 IDLE: start=1 -> APPLY, vec=0x00, all counters and ff_* cleared, busy=1 next cycle.
REQ-015 APPLY: 1 cycle, sk_in holds vec; WAIT: exactly SK_LAT cycles (skipped when SK_LAT=0); CHECK: 1 cycle, samples sk_x.
REQ-016 CHECK SHALL compute ic = s[3] | (s >=u t) and sat = ((s >>a sk_x) >=u t); arithmetic shift, amounts >=3 yield 4 copies of s[3].
REQ-017 CHECK: ic=0 -> skip_cnt+1; ic=1 & sat=1 -> pass_cnt+1; ic=1 & sat=0 -> fail_cnt+1.
REQ-018 First ic=1 & sat=0 event per sweep SHALL load ff_vec=vec, ff_x=sk_x, ff_valid=1; later failures SHALL not overwrite.
REQ-019 CHECK with vec=0xFF -> DONE; otherwise vec+1 -> APPLY; vec SHALL not wrap within a sweep.
REQ-020 DONE: done=1 for one cycle, busy=0 in same cycle, -> IDLE; counters and ff_* held until next accepted start.
REQ-021 Sweep length SHALL be 256*(2+SK_LAT) cycles from first APPLY to DONE.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 abort=1 in any non-IDLE state SHALL -> IDLE next cycle, busy=0, no done pulse, counters and ff_* frozen; abort has priority over start and CHECK updates in same cycle.
REQ-024 pass_cnt+fail_cnt+skip_cnt SHALL equal 256 at done.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, sk_in=0x00, busy=0, done=0, all counters=0, ff_valid=0, ff_vec=0x00, ff_x=0x0.
REQ-026 Reset asserted mid-sweep SHALL discard the sweep; first post-reset start begins a fresh sweep at vec=0x00.

Verification
REQ-027 Ideal Skolem model (any x satisfying when ic=1), SK_LAT=0 -> done after 512 cycles, pass=164, fail=0, skip=92, ff_valid=0.
REQ-028 Constant sk_x=0 -> pass=136, fail=28, skip=92, ff_valid=1, ff_vec=0x98, ff_x=0x0.
REQ-029 SK_LAT=3 with ideal model delayed 3 cycles -> done exactly 1280 cycles after first APPLY, counts as REQ-027.
REQ-030 abort during CHECK of vec=0x40 -> busy=0 next cycle, no done, counters frozen without the 0x40 update; new start restarts at 0x00 with counters cleared.
REQ-031 start pulsed at vec=0x80 mid-sweep -> no effect; rst_n low at vec=0x80 -> all outputs at reset values immediately.
